// File: rtl/servo_pwm.sv
// rtl/servo_pwm.sv - servo pulse generator with per-frame angle slew and frame watchdog
module servo_pwm #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int MIN_CYC   = 50_000,
   parameter int DEG_CYC   = 278,
   parameter int MAX_ANGLE = 180,
   parameter int STEP      = 2,
   parameter int WD_CYC    = 2_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       frame_in,
   input  logic [7:0] tgt_angle,
   input  logic       tgt_valid,
   output logic       tgt_ready,
   output logic       pwm_out,
   output logic [7:0] cur_angle,
   output logic       busy,
   output logic       fault
);

   // The watchdog is never allowed to wait longer than one second of clock.
   localparam int WD_LIM = (WD_CYC < CLK_FREQ) ? WD_CYC : CLK_FREQ;
   localparam logic [7:0] MAX_A  = 8'(MAX_ANGLE);
   localparam logic [7:0] STEP_A = 8'(STEP);

   typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

   state_t      state_q;
   logic        frame_q;
   logic        pwm_q;
   logic        fault_q;
   logic [7:0]  cur_q;
   logic [7:0]  tgt_q;
   logic [31:0] width_q;
   logic [31:0] cnt_q;
   logic [31:0] wd_q;

   logic        frame_edge;
   logic        wd_hit;
   logic [7:0]  diff;
   logic [7:0]  step;
   logic [7:0]  cur_d;
   logic [7:0]  tgt_d;
   logic [31:0] width_d;

   always_comb begin
      frame_edge = frame_in & ~frame_q;
      wd_hit     = ~frame_edge && (wd_q == 32'(WD_LIM - 1));
      diff       = (tgt_q > cur_q) ? (tgt_q - cur_q) : (cur_q - tgt_q);
      step       = (diff < STEP_A) ? diff : STEP_A;
      cur_d      = (tgt_q > cur_q) ? (cur_q + step) : (cur_q - step);
      width_d    = 32'(MIN_CYC) + 32'(cur_d) * 32'(DEG_CYC);
      tgt_d      = (tgt_angle > MAX_A) ? MAX_A : tgt_angle;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         frame_q <= 1'b0;
         pwm_q   <= 1'b0;
         fault_q <= 1'b0;
         cur_q   <= 8'd90;
         tgt_q   <= 8'd90;
         width_q <= '0;
         cnt_q   <= '0;
         wd_q    <= '0;
      end else begin
         frame_q <= frame_in;
         if (tgt_valid) tgt_q <= tgt_d;

         if (frame_edge)                wd_q <= '0;
         else if (wd_q != 32'(WD_LIM))  wd_q <= wd_q + 32'd1;

         // Watchdog expiry overrides everything, including a pulse in flight.
         if (wd_hit) begin
            fault_q <= 1'b1;
            state_q <= IDLE;
            pwm_q   <= 1'b0;
            cnt_q   <= '0;
         end else begin
            case (state_q)
               IDLE, LOW: begin
                  if (frame_edge) begin
                     state_q <= HIGH;
                     pwm_q   <= 1'b1;
                     cnt_q   <= 32'd1;
                     cur_q   <= cur_d;
                     width_q <= width_d;
                     fault_q <= 1'b0;
                  end
               end
               HIGH: begin
                  if (cnt_q >= width_q) begin
                     state_q <= LOW;
                     pwm_q   <= 1'b0;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q   <= cnt_q + 32'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
                  pwm_q   <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tgt_ready = rst;
   assign pwm_out   = pwm_q;
   assign cur_angle = cur_q;
   assign busy      = (cur_q != tgt_q);
   assign fault     = fault_q;

endmodule
